// File: rtl/dmem_arbiter_if.sv
// Bundle of pipeline, debug and data-memory signals around the dmem arbiter.
// slave = arbiter view; master = requesters plus the memory device.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [2:0]        core_funct3;
  logic [DATA_W-1:0] core_rdata;
  logic              core_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [2:0]        dbg_funct3;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_funct3;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, core_funct3,
    output core_rdata, core_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_funct3,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_funct3,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata, core_funct3,
    input  core_rdata, core_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_funct3,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_funct3,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin sharing of one data-memory port between the pipeline MEM stage and a debug master.
// Latency: grant -> ISSUE -> RESP, 3 cycles per access; core_stall holds the pipeline, debug holds until dbg_gnt.
// Optional macro DMEM_ARB_STATS_EN adds the saturating core_wait_cnt output.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  dmem_arbiter_if.slave bus,
  output logic          busy
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   core_wait_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [2:0]        funct3;
  } acc_t;

  state_t state, state_nxt;
  acc_t   lat;
  logic   owner_dbg;
  logic   last_dbg;
  logic   core_cand, dbg_cand;
  logic   core_win, dbg_win;

  // The owner of the access in RESP may not win again until the other side had its chance.
  always_comb begin
    core_cand = 1'b0;
    dbg_cand  = 1'b0;
    if (state == IDLE) begin
      core_cand = bus.core_req;
      dbg_cand  = bus.dbg_req;
    end else if (state == RESP) begin
      core_cand = bus.core_req & owner_dbg;
      dbg_cand  = bus.dbg_req & ~owner_dbg;
    end
  end

  assign core_win = enable & ~rst & core_cand & (~dbg_cand | last_dbg);
  assign dbg_win  = enable & ~rst & dbg_cand & (~core_cand | ~last_dbg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = (core_win | dbg_win) ? ISSUE : IDLE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = (core_win | dbg_win) ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat       <= '0;
      owner_dbg <= 1'b0;
      last_dbg  <= 1'b1;
    end else if (core_win) begin
      lat       <= {bus.core_we, bus.core_addr, bus.core_wdata, bus.core_funct3};
      owner_dbg <= 1'b0;
      last_dbg  <= 1'b0;
    end else if (dbg_win) begin
      lat       <= {bus.dbg_we, bus.dbg_addr, bus.dbg_wdata, bus.dbg_funct3};
      owner_dbg <= 1'b1;
      last_dbg  <= 1'b1;
    end
  end

  always_comb begin
    bus.mem_en     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_funct3 = '0;
    bus.core_rdata = '0;
    bus.dbg_rvalid = 1'b0;
    bus.dbg_rdata  = '0;
    case (state)
      ISSUE: begin
        bus.mem_en     = 1'b1;
        bus.mem_we     = lat.we;
        bus.mem_addr   = lat.addr;
        bus.mem_wdata  = lat.wdata;
        bus.mem_funct3 = lat.funct3;
      end
      RESP: begin
        if (!owner_dbg) begin
          bus.core_rdata = bus.mem_rdata;
        end else if (!lat.we) begin
          bus.dbg_rvalid = 1'b1;
          bus.dbg_rdata  = bus.mem_rdata;
        end
      end
      default: ;
    endcase
  end

  assign bus.dbg_gnt    = dbg_win;
  assign bus.core_stall = bus.core_req & ~((state == RESP) & ~owner_dbg);
  assign busy           = (state != IDLE);

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_wait_cnt <= '0;
    end else if (bus.core_stall && (core_wait_cnt != 16'hFFFF)) begin
      core_wait_cnt <= core_wait_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, width of all address buses.
REQ-002 Parameter: DATA_W, 32, width of all data buses.
REQ-003 Port: clk  input  1  single clock; all state on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: enable  input  1  high permits new grants; low blocks new grants only.
REQ-006 Port: core_req / core_we  input  1/1  pipeline MEM-stage access request / write strobe.
REQ-007 Port: core_addr, core_wdata, core_funct3  input  ADDR_W, DATA_W, 3  pipeline access fields.
REQ-008 Port: core_rdata  output  DATA_W  read data to pipeline; core_stall  output  1  freezes pipeline.
REQ-009 Port: dbg_req / dbg_we  input  1/1  debug/loader request / write strobe.
REQ-010 Port: dbg_addr, dbg_wdata, dbg_funct3  input  ADDR_W, DATA_W, 3  debug access fields.
REQ-011 Port: dbg_gnt, dbg_rvalid  output  1/1  request accepted pulse / read data valid pulse; dbg_rdata  output  DATA_W.
REQ-012 Port: mem_en, mem_we  output  1/1  data-memory access / write strobe.
REQ-013 Port: mem_addr, mem_wdata, mem_funct3  output  ADDR_W, DATA_W, 3  to data memory; mem_rdata  input  DATA_W, valid one cycle after mem_en.
REQ-014 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, RESP; owner register SHALL record CORE or DBG; last register SHALL record last-served requester.
REQ-016 Arbitration cycle (IDLE, or RESP for the non-owner): single requester wins; both requesting -> requester not equal to last wins (round-robin); no winner with enable=0.
REQ-017 On grant SHALL latch winner's we/addr/wdata/funct3, set owner, update last, go to ISSUE next cycle.
REQ-018 dbg_gnt SHALL pulse high exactly in the arbitration cycle where DBG wins; debug holds fields until dbg_gnt.
REQ-019 ISSUE: mem_en=1, mem_we/addr/wdata/funct3 from latched fields; next state RESP unconditionally.
REQ-020 RESP: owner CORE -> core_rdata=mem_rdata, core_stall=0; owner DBG and latched we=0 -> dbg_rvalid=1, dbg_rdata=mem_rdata.
REQ-021 RESP exit: non-owner requesting and enable=1 -> granted, next ISSUE; otherwise IDLE. Owner's still-high request in RESP SHALL NOT be re-granted.
REQ-022 core_stall = core_req AND NOT (state==RESP AND owner==CORE); one core access = 3 cycles (request cycle 0, stall low cycle 2).
REQ-023 Writes SHALL traverse ISSUE and RESP identically; dbg_rvalid SHALL stay low for debug writes.
REQ-024 mem_en/mem_we SHALL be 0 in IDLE and RESP; core_rdata/dbg_rdata SHALL be 0 outside their RESP cycle.
REQ-025 enable falling mid-access SHALL NOT abort ISSUE/RESP; access completes, then FSM idles.
REQ-026 funct3 SHALL pass unmodified; no alignment checking.

Reset
REQ-027 rst high SHALL immediately force IDLE, owner=CORE, last=DBG, latched fields 0, all outputs 0 (core_stall follows core_req).
REQ-028 rst asserted during ISSUE SHALL drop mem_en/mem_we asynchronously; aborted access produces no response.

Configuration
REQ-029 Macro DMEM_ARB_STATS_EN defined: add output core_wait_cnt [15:0], +1 each cycle core_stall=1, saturates at 16'hFFFF, cleared by rst.
REQ-030 Macro undefined: port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-031 Core read only, addr 0x10, mem holds 0x01010101 -> mem_en cycle 1, core_stall low and core_rdata=0x01010101 cycle 2.
REQ-032 Core and dbg request same cycle after reset (last=DBG) -> CORE served first, dbg_gnt pulses in core's RESP cycle, dbg access ISSUE next cycle.
REQ-033 Both requesting continuously 6 accesses -> grants alternate CORE,DBG,CORE,DBG,CORE,DBG; no back-to-back same owner.
REQ-034 Dbg write addr 0x4 data 0xDEADBEEF funct3 010 -> one mem_en/mem_we pulse with those values, dbg_rvalid stays 0.
REQ-035 rst pulse during ISSUE of dbg read -> mem_en low same cycle, no dbg_rvalid, busy=0; next core read completes in 3 cycles.
REQ-036 With DMEM_ARB_STATS_EN, core read while dbg owns bus (core waits 4 stall cycles) -> core_wait_cnt=4.
